id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Parametrised successor to the fixed-field ID/EX latch.
- Generic pipeline stage register with valid/ready handshake, cache-hit freeze, flush-to-bubble and an optional 2-entry skid buffer.
- Sits between decode and execute and is reusable for EX/MEM and MEM/WB.
- Payload is split into DATA (operands, immediate, PC; held on bubble) and CTRL (write-enable/mem-enable bits; forced to zero on bubble, so a bubble never writes).

Parameters:
- DATA_W, 112: width of the datapath payload (two operands, immediate, next PC, register fields).
- CTRL_W, 16: width of the control payload; zeroed whenever the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk (pipeline convention).
- rst_n  in  1  synchronous active-low reset, sampled on negedge clk.
- hit  in  1  cache-hit enable; 0 freezes the stage completely.
- flush  in  1  synchronous flush; converts all held entries to bubbles.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents a valid entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-entry datapath payload.
- out_ctrl  out  CTRL_W  head-entry control payload; 0 when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Events: in_fire = in_valid & in_ready & hit; out_fire = out_valid & out_ready & hit.
- Reset (rst_n=0 at a negedge): out_valid=0, out_ctrl=0, out_data=0, skid entry empty, stall_cnt=0. in_ready=0 combinationally while rst_n=0. Reset wins over flush, hit and all handshakes.
- Latency: 1 negedge from in_fire to out_valid. Throughput: 1 entry/cycle with out_ready held high.
- SKID=0:
  - in_ready = rst_n & hit & (!out_valid | out_ready).
  - On in_fire, load main from in_*.
  - On out_fire without in_fire, out_valid<=0 and out_ctrl<=0.
- SKID=1: state machine over {EMPTY, ONE, FULL}. main drives out_*; skid is the hidden second entry.
  - in_ready = rst_n & hit & (state != FULL). This is registered state plus hit only, with no out_ready path.
  - EMPTY: in_fire -> ONE (main<=in).
  - ONE: in_fire & out_fire -> ONE (main<=in). in_fire only -> FULL (skid<=in). out_fire only -> EMPTY (out_ctrl<=0).
  - FULL: out_fire -> ONE (main<=skid). Otherwise hold.
  - Ordering is preserved: skid never bypasses main.
- hit=0: no fires and no state change; all outputs hold; stall_cnt does not count. Freezes regardless of in_valid/out_ready.
- flush=1 (rst_n=1): next state EMPTY, out_valid<=0, out_ctrl<=0, skid discarded, out_data holds.
  - flush overrides hit=0 and any simultaneous in_fire: the incoming entry is dropped, and the upstream stage flushes itself.
  - in_ready is unaffected by flush in the same cycle.
- stall_cnt increments by 1 on each negedge with out_valid & !out_ready & hit & !flush. It saturates at 2^CNT_W-1 (no wrap) and is cleared only by reset.
- No X propagation: out_data is reset to 0 and is never loaded from an undriven skid.

Test Plan:
1. Reset: drive rst_n=0 for 2 negedges with in_valid=1, hit=1 -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=0. Release -> in_ready=1 (SKID=1).
2. Streaming (SKID=1, out_ready=1, hit=1): send data 1..8 back-to-back -> out_data equals 1..8 in order, each one negedge after its in_fire, with no gaps; stall_cnt stays 0.
3. Skid fill: send A and B while out_ready=0 -> state FULL, in_ready=0, out_data=A, stall_cnt counting. Raise out_ready -> A then B emitted in order; in_ready returns to 1 after the first out_fire.
4. Flush in FULL with simultaneous in_valid=1 (entry C) -> next negedge out_valid=0, out_ctrl=0, C dropped and B lost; following in_fire of D -> out_data=D.
5. Freeze: hit=0 for 5 cycles with out_ready=1 and in_valid=1 -> all outputs and stall_cnt constant, in_ready=0. With hit=1 restored, flow resumes in order with no duplicates.
6. Saturation (CNT_W=3): hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt goes 1..7 and stays 7. Repeat cases 2–3 with SKID=0 -> in_ready follows out_ready combinationally and the same ordering holds.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Generic pipeline stage register with valid/ready handshake, hit freeze, flush-to-bubble
// and an optional two-entry skid buffer; state advances on the falling clock edge.
module id_ex_pipe_reg #(
    parameter int DATA_W = 112,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic in_fire, out_fire;
    logic load_in, load_skid, pop_skid;

    assign out_valid = (state != EMPTY);

    // With the skid buffer, in_ready depends only on registered state and hit.
    always_comb begin
        if (SKID != 0) in_ready = rst_n & hit & (state != FULL);
        else           in_ready = rst_n & hit & (!out_valid | out_ready);
    end

    assign in_fire  = in_valid & in_ready & hit;
    assign out_fire = out_valid & out_ready & hit;

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    load_in   = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && (out_fire || SKID == 0)) begin
                    load_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    pop_skid  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush turns everything held into bubbles and drops any incoming entry.
        if (flush) begin
            state_nxt = EMPTY;
            load_in   = 1'b0;
            load_skid = 1'b0;
            pop_skid  = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_in) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
            end else if (pop_skid) begin
                out_data <= skid_data;
                out_ctrl <= skid_ctrl;
            end else if (state_nxt == EMPTY) begin
                out_ctrl <= '0;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
            if (out_valid && !out_ready && hit && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
